// File: rtl/chacha_stream.sv
// Memory-mapped ChaCha keystream engine: register file, block FSM with a latched
// output buffer and auto prefetch, plus the iterative ChaCha block core it drives.
module chacha_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [63:0]  iv,
  input  logic [63:0]  ctr,
  input  logic [4:0]   rounds,
  input  logic [511:0] data_in,
  output logic         ready,
  output logic [511:0] data_out,
  output logic         data_out_valid
);
  typedef logic [15:0][31:0] blk_t;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic blk_t qr(input blk_t s, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
    blk_t t;
    t = s;
    t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 16);
    t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 12);
    t[a] = t[a] + t[b]; t[d] = rotl(t[d] ^ t[a], 8);
    t[c] = t[c] + t[d]; t[b] = rotl(t[b] ^ t[c], 7);
    return t;
  endfunction

  function automatic blk_t dround(input blk_t s);
    blk_t t;
    t = qr(s, 4'd0, 4'd4, 4'd8,  4'd12);
    t = qr(t, 4'd1, 4'd5, 4'd9,  4'd13);
    t = qr(t, 4'd2, 4'd6, 4'd10, 4'd14);
    t = qr(t, 4'd3, 4'd7, 4'd11, 4'd15);
    t = qr(t, 4'd0, 4'd5, 4'd10, 4'd15);
    t = qr(t, 4'd1, 4'd6, 4'd11, 4'd12);
    t = qr(t, 4'd2, 4'd7, 4'd8,  4'd13);
    t = qr(t, 4'd3, 4'd4, 4'd9,  4'd14);
    return t;
  endfunction

  blk_t             x_q, x_d, base_q, base_d, ld;
  logic [511:0]     out_q, out_d;
  logic [7:0][31:0] kw;
  logic [15:0][31:0] dw, ow;
  logic [5:0]       rnd_q, rnd_d;
  logic             busy_q, busy_d, ready_q, ready_d, valid_q, valid_d;

  always_comb begin
    kw = key;
    dw = data_in;
    // Key bytes are big-endian on the bus; state words are little-endian.
    ld[0] = 32'h61707865;
    ld[1] = keylen ? 32'h3320646e : 32'h3120646e;
    ld[2] = keylen ? 32'h79622d32 : 32'h79622d36;
    ld[3] = 32'h6b206574;
    for (int i = 0; i < 4; i++) begin
      ld[4 + i] = bswap(kw[7 - i]);
      ld[8 + i] = keylen ? bswap(kw[3 - i]) : bswap(kw[7 - i]);
    end
    ld[12] = ctr[31:0];
    ld[13] = ctr[63:32];
    ld[14] = bswap(iv[63:32]);
    ld[15] = bswap(iv[31:0]);

    ow = '0;
    for (int i = 0; i < 16; i++) ow[15 - i] = bswap(x_q[i] + base_q[i]) ^ dw[15 - i];

    x_d = x_q; base_d = base_q; out_d = out_q; rnd_d = rnd_q;
    busy_d = busy_q; ready_d = ready_q; valid_d = valid_q;
    if (init) begin
      x_d = ld; base_d = ld; rnd_d = '0;
      busy_d = 1'b1; ready_d = 1'b0; valid_d = 1'b0;
    end else if (busy_q) begin
      if (rnd_q >= {1'b0, rounds}) begin
        out_d = ow; busy_d = 1'b0; ready_d = 1'b1; valid_d = 1'b1;
      end else begin
        x_d = dround(x_q);
        rnd_d = rnd_q + 6'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q <= '0; base_q <= '0; out_q <= '0; rnd_q <= '0;
      busy_q <= 1'b0; ready_q <= 1'b1; valid_q <= 1'b0;
    end else begin
      x_q <= x_d; base_q <= base_d; out_q <= out_d; rnd_q <= rnd_d;
      busy_q <= busy_d; ready_q <= ready_d; valid_q <= valid_d;
    end
  end

  assign ready          = ready_q;
  assign data_out       = out_q;
  assign data_out_valid = valid_q;
endmodule

module chacha_stream #(
  parameter logic [63:0] CTR_INIT       = 64'h0,
  parameter logic [4:0]  DEFAULT_ROUNDS = 5'd20,
  parameter logic        DEFAULT_KEYLEN = 1'b1,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_PEND} state_t;

  state_t            state_q, state_d;
  logic [7:0][31:0]  key_q, key_d;
  logic [1:0][31:0]  iv_q, iv_d;
  logic [15:0][31:0] din_q, din_d, out_buf_q, out_buf_d;
  logic [63:0]       ctr_q, ctr_d;
  logic [4:0]        rounds_q, rounds_d;
  logic [CNT_WIDTH-1:0] blocks_q, blocks_d;
  logic              keylen_q, keylen_d, auto_q, auto_d, irq_en_q, irq_en_d;
  logic              err_q, err_d, pending_q, pending_d, buf_full_q, buf_full_d;
  logic              wait_first_q, wait_first_d;
  logic              idle, pop, cfg_addr, err_set, err_clr, start_req, xfer;
  logic              core_ready, core_valid;
  logic [511:0]      core_data_out;
  logic [31:0]       blocks_ext;

  assign idle = (state_q == S_IDLE);
  assign irq  = irq_en_q & buf_full_q;

  chacha_core u_core (
    .clk            (clk),
    .reset_n        (~reset),
    .init           (state_q == S_START),
    .keylen         (keylen_q),
    .key            (key_q),
    .iv             (iv_q),
    .ctr            (ctr_q),
    .rounds         (rounds_q),
    .data_in        (din_q),
    .ready          (core_ready),
    .data_out       (core_data_out),
    .data_out_valid (core_valid)
  );

  always_comb begin
    state_d = state_q; key_d = key_q; iv_d = iv_q; din_d = din_q; out_buf_d = out_buf_q;
    ctr_d = ctr_q; rounds_d = rounds_q; blocks_d = blocks_q; keylen_d = keylen_q;
    auto_d = auto_q; irq_en_d = irq_en_q; pending_d = pending_q; buf_full_d = buf_full_q;
    wait_first_d = 1'b0;
    err_set = 1'b0; err_clr = 1'b0; start_req = 1'b0; xfer = 1'b0;
    pop = cs & ~we & (addr == 8'h8f);

    case (addr) inside
      8'h0a, 8'h0b, 8'h0c, 8'h0d, [8'h10:8'h17], [8'h20:8'h21], [8'h40:8'h4f]: cfg_addr = 1'b1;
      default: cfg_addr = 1'b0;
    endcase

    if (cs && we) begin
      if (cfg_addr && !idle) err_set = 1'b1;
      case (addr)
        8'h08: begin
          auto_d   = write_data[1] & ~write_data[3];
          irq_en_d = write_data[2];
          if (write_data[0]) begin
            if (idle) start_req = 1'b1;
            else      err_set   = 1'b1;
          end
          if (idle && write_data[1] && !write_data[3]) start_req = 1'b1;
        end
        8'h09:   err_clr  = write_data[3];
        8'h0e:   blocks_d = '0;
        default: ;
      endcase
      if (idle) begin
        case (addr) inside
          8'h0a:          keylen_d           = write_data[0];
          8'h0b:          rounds_d           = write_data[4:0];
          8'h0c:          ctr_d[31:0]        = write_data;
          8'h0d:          ctr_d[63:32]       = write_data;
          [8'h10:8'h17]:  key_d[~addr[2:0]]  = write_data;
          [8'h20:8'h21]:  iv_d[~addr[0]]     = write_data;
          [8'h40:8'h4f]:  din_d[~addr[3:0]]  = write_data;
          default: ;
        endcase
      end
    end
    err_d = (err_q & ~err_clr) | err_set;

    if (pop) buf_full_d = 1'b0;

    case (state_q)
      S_IDLE:  if (start_req) state_d = S_START;
      S_START: begin
        state_d      = S_WAIT;
        wait_first_d = 1'b1;
      end
      S_WAIT: begin
        if (!wait_first_q && core_ready && core_valid) begin
          if (!buf_full_q) xfer = 1'b1;
          else begin
            state_d   = S_PEND;
            pending_d = 1'b1;
          end
        end
      end
      S_PEND:  if (!buf_full_q || pop) xfer = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A transfer in the same cycle as a pop wins: the buffer refills with the new block.
    if (xfer) begin
      out_buf_d  = core_data_out;
      buf_full_d = 1'b1;
      ctr_d      = ctr_q + 64'd1;
      blocks_d   = blocks_d + 1'b1;
      pending_d  = 1'b0;
      state_d    = auto_d ? S_START : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; key_q <= '0; iv_q <= '0; din_q <= '0; out_buf_q <= '0;
      ctr_q <= CTR_INIT; rounds_q <= DEFAULT_ROUNDS; keylen_q <= DEFAULT_KEYLEN;
      blocks_q <= '0; auto_q <= 1'b0; irq_en_q <= 1'b0; err_q <= 1'b0;
      pending_q <= 1'b0; buf_full_q <= 1'b0; wait_first_q <= 1'b0;
    end else begin
      state_q <= state_d; key_q <= key_d; iv_q <= iv_d; din_q <= din_d; out_buf_q <= out_buf_d;
      ctr_q <= ctr_d; rounds_q <= rounds_d; keylen_q <= keylen_d;
      blocks_q <= blocks_d; auto_q <= auto_d; irq_en_q <= irq_en_d; err_q <= err_d;
      pending_q <= pending_d; buf_full_q <= buf_full_d; wait_first_q <= wait_first_d;
    end
  end

  always_comb begin
    blocks_ext = '0;
    blocks_ext[CNT_WIDTH-1:0] = blocks_q;
    read_data = '0;
    if (cs && !we) begin
      case (addr) inside
        8'h00:         read_data = 32'h63686163;
        8'h01:         read_data = 32'h68612020;
        8'h02:         read_data = 32'h312e3030;
        8'h08:         read_data = {29'h0, irq_en_q, auto_q, 1'b0};
        8'h09:         read_data = {28'h0, err_q, pending_q, buf_full_q, idle};
        8'h0a:         read_data = {31'h0, keylen_q};
        8'h0b:         read_data = {27'h0, rounds_q};
        8'h0c:         read_data = ctr_q[31:0];
        8'h0d:         read_data = ctr_q[63:32];
        8'h0e:         read_data = blocks_ext;
        [8'h10:8'h17]: read_data = key_q[~addr[2:0]];
        [8'h20:8'h21]: read_data = iv_q[~addr[0]];
        [8'h80:8'h8f]: read_data = out_buf_q[~addr[3:0]];
        default:       read_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_stream.sv
// Self-checking bench for chacha_stream: directed bus sequence with random keys
// and a byte-level ChaCha reference model.
module tb_chacha_stream;
  typedef logic [15:0][31:0] words_t;

  logic        clk = 1'b0;
  logic        reset, cs, we, irq;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata, v;
  int          checks = 0;
  int          errors = 0;

  logic [255:0] sk;
  logic [63:0]  siv, sctr;
  logic [511:0] sdin, blk;
  logic [4:0]   srnd;
  logic         skl;
  int           nblk;

  chacha_stream dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .we         (we),
    .addr       (addr),
    .write_data (wdata),
    .read_data  (rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] le32(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic words_t quarter(input words_t w, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
    words_t t;
    t = w;
    t[a] += t[b]; t[d] = rol(t[d] ^ t[a], 16);
    t[c] += t[d]; t[b] = rol(t[b] ^ t[c], 12);
    t[a] += t[b]; t[d] = rol(t[d] ^ t[a], 8);
    t[c] += t[d]; t[b] = rol(t[b] ^ t[c], 7);
    return t;
  endfunction

  // Keystream block serialized to bytes, XORed with the 64-byte input, first byte at MSB.
  function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [63:0] iv,
                                             input logic [63:0] ctr, input logic [4:0] rounds,
                                             input logic keylen, input logic [511:0] din);
    logic [7:0]   kb[32];
    logic [7:0]   sb[16];
    logic [7:0]   ib[8];
    logic [127:0] sig;
    logic [31:0]  w;
    logic [511:0] res;
    words_t       s, x;
    int           k;
    sig = keylen ? "expand 32-byte k" : "expand 16-byte k";
    for (int i = 0; i < 32; i++) kb[i] = key[255 - 8*i -: 8];
    for (int i = 0; i < 16; i++) sb[i] = sig[127 - 8*i -: 8];
    for (int i = 0; i < 8; i++)  ib[i] = iv[63 - 8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      s[i]     = le32(sb[4*i], sb[4*i+1], sb[4*i+2], sb[4*i+3]);
      s[4 + i] = le32(kb[4*i], kb[4*i+1], kb[4*i+2], kb[4*i+3]);
      s[8 + i] = keylen ? le32(kb[16+4*i], kb[17+4*i], kb[18+4*i], kb[19+4*i])
                        : le32(kb[4*i], kb[4*i+1], kb[4*i+2], kb[4*i+3]);
    end
    s[12] = ctr[31:0];
    s[13] = ctr[63:32];
    s[14] = le32(ib[0], ib[1], ib[2], ib[3]);
    s[15] = le32(ib[4], ib[5], ib[6], ib[7]);
    x = s;
    for (int r = 0; r < int'(rounds); r += 2) begin
      x = quarter(x, 4'd0, 4'd4, 4'd8,  4'd12);
      x = quarter(x, 4'd1, 4'd5, 4'd9,  4'd13);
      x = quarter(x, 4'd2, 4'd6, 4'd10, 4'd14);
      x = quarter(x, 4'd3, 4'd7, 4'd11, 4'd15);
      x = quarter(x, 4'd0, 4'd5, 4'd10, 4'd15);
      x = quarter(x, 4'd1, 4'd6, 4'd11, 4'd12);
      x = quarter(x, 4'd2, 4'd7, 4'd8,  4'd13);
      x = quarter(x, 4'd3, 4'd4, 4'd9,  4'd14);
    end
    res = '0;
    for (int i = 0; i < 16; i++) begin
      w = x[i] + s[i];
      for (int j = 0; j < 4; j++) begin
        k = 4*i + j;
        res[511 - 8*k -: 8] = w[8*j +: 8] ^ din[511 - 8*k -: 8];
      end
    end
    return res;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1; cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(posedge clk); #1; cs = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic poll(input int bitn, input string tag);
    logic [31:0] d;
    d = '0;
    for (int n = 0; n < 300; n++) begin
      rd(8'h09, d);
      if (d[bitn]) break;
    end
    chk(tag, {31'b0, d[bitn]}, 32'd1);
  endtask

  task automatic chk_block(input string tag, input logic [511:0] exp);
    for (int i = 0; i < 16; i++)
      rchk($sformatf("%s_w%0d", tag, i), 8'(8'h80 + i), exp[511 - 32*i -: 32]);
  endtask

  task automatic load_cfg();
    for (int i = 0; i < 8; i++)  wr(8'(8'h10 + i), sk[255 - 32*i -: 32]);
    for (int i = 0; i < 2; i++)  wr(8'(8'h20 + i), siv[63 - 32*i -: 32]);
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), sdin[511 - 32*i -: 32]);
    wr(8'h0a, {31'b0, skl});
    wr(8'h0b, {27'b0, srnd});
    wr(8'h0c, sctr[31:0]);
    wr(8'h0d, sctr[63:32]);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    do_reset();

    chk("rst_irq", {31'b0, irq}, 32'd0);
    rchk("name0", 8'h00, 32'h63686163);
    rchk("name1", 8'h01, 32'h68612020);
    rchk("version", 8'h02, 32'h312e3030);
    rchk("rst_rounds", 8'h0b, 32'h14);
    rchk("rst_ctr_lo", 8'h0c, 32'h0);
    rchk("rst_ctr_hi", 8'h0d, 32'h0);
    rchk("rst_keylen", 8'h0a, 32'h1);
    rchk("rst_ctrl", 8'h08, 32'h0);
    rchk("rst_status", 8'h09, 32'h1);
    rchk("rst_blocks", 8'h0e, 32'h0);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 8'h00; wdata = '0;
    #1 chk("rdata_we_high", rdata, 32'h0);
    @(posedge clk); #1; cs = 1'b0; we = 1'b0;
    #1 chk("rdata_cs_low", rdata, 32'h0);

    // Zero key/IV single block
    sk = '0; siv = '0; sctr = '0; sdin = '0; srnd = 5'd20; skl = 1'b1;
    load_cfg();
    wr(8'h08, 32'h1);
    poll(1, "zero_full");
    rchk("zero_out0", 8'h80, 32'h76b8e0ad);
    rchk("zero_out1", 8'h81, 32'ha0f13d90);
    chk_block("zero", ref_block(sk, siv, sctr, srnd, skl, sdin));
    rchk("zero_ctr_lo", 8'h0c, 32'h1);
    rchk("zero_blocks", 8'h0e, 32'h1);
    rchk("zero_popped", 8'h09, 32'h1);
    nblk = 1;

    // Random key/iv/data/counter/rounds/keylen
    for (int it = 0; it < 4; it++) begin
      sk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      siv = {$urandom, $urandom};
      sctr = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) sdin[32*i +: 32] = $urandom;
      srnd = (it == 0) ? 5'd20 : 5'($urandom_range(0, 31));
      skl = 1'($urandom_range(0, 1));
      load_cfg();
      rchk($sformatf("rnd%0d_key0", it), 8'h10, sk[255:224]);
      rchk($sformatf("rnd%0d_iv1", it), 8'h21, siv[31:0]);
      rchk($sformatf("rnd%0d_rounds", it), 8'h0b, {27'b0, srnd});
      wr(8'h08, 32'h1);
      poll(1, $sformatf("rnd%0d_full", it));
      chk_block($sformatf("rnd%0d", it), ref_block(sk, siv, sctr, srnd, skl, sdin));
      sctr = sctr + 64'd1;
      nblk++;
      rchk($sformatf("rnd%0d_ctr_lo", it), 8'h0c, sctr[31:0]);
      rchk($sformatf("rnd%0d_ctr_hi", it), 8'h0d, sctr[63:32]);
      rchk($sformatf("rnd%0d_blocks", it), 8'h0e, 32'(nblk));
    end

    // Counter wrap
    sctr = '1;
    load_cfg();
    wr(8'h08, 32'h1);
    poll(1, "wrap_full");
    chk_block("wrap", ref_block(sk, siv, sctr, srnd, skl, sdin));
    rchk("wrap_ctr_lo", 8'h0c, 32'h0);
    rchk("wrap_ctr_hi", 8'h0d, 32'h0);

    // Auto mode with prefetch, then STOP during the prefetch
    sk = '0; siv = '0; sctr = '0; sdin = '0; srnd = 5'd20; skl = 1'b1;
    load_cfg();
    wr(8'h0e, 32'h0);
    wr(8'h08, 32'h6);
    poll(1, "auto_full");
    rchk("auto_out0", 8'h80, 32'h76b8e0ad);
    chk("auto_irq", {31'b0, irq}, 32'd1);
    poll(2, "auto_pending");
    rchk("auto_status_pend", 8'h09, 32'h6);
    chk_block("auto_b0", ref_block(sk, siv, 64'd0, srnd, skl, sdin));
    poll(1, "auto_full2");
    rchk("auto_b1_out0", 8'h80, 32'h9f07e7be);
    rchk("auto_blocks", 8'h0e, 32'h2);
    chk("auto_irq_held", {31'b0, irq}, 32'd1);
    wr(8'h08, 32'hc);
    rchk("stop_ctrl", 8'h08, 32'h4);
    poll(2, "stop_pending");
    chk_block("auto_b1", ref_block(sk, siv, 64'd1, srnd, skl, sdin));
    poll(1, "stop_full");
    rchk("stop_status", 8'h09, 32'h3);
    rchk("stop_blocks", 8'h0e, 32'h3);
    rchk("stop_ctr_lo", 8'h0c, 32'h3);
    blk = ref_block(sk, siv, 64'd2, srnd, skl, sdin);
    rchk("stop_b2_out0", 8'h80, blk[511:480]);
    repeat (40) @(posedge clk);
    rchk("stop_no_restart", 8'h09, 32'h3);
    rchk("stop_blocks_hold", 8'h0e, 32'h3);
    rd(8'h8f, v);
    rchk("stop_popped", 8'h09, 32'h1);
    chk("stop_irq_low", {31'b0, irq}, 32'd0);

    // Writes while busy are dropped and flag err
    sctr = 64'd3;
    wr(8'h08, 32'h1);
    wr(8'h10, 32'hdeadbeef);
    wr(8'h08, 32'h1);
    rd(8'h09, v);
    chk("busy_err", v & 32'h8, 32'h8);
    poll(1, "busy_full");
    rchk("busy_key0", 8'h10, 32'h0);
    repeat (40) @(posedge clk);
    rchk("busy_blocks", 8'h0e, 32'h4);
    chk_block("busy", ref_block(sk, siv, sctr, srnd, skl, sdin));
    wr(8'h09, 32'h8);
    rchk("err_cleared", 8'h09, 32'h1);

    // Reset in the middle of a block
    wr(8'h08, 32'h1);
    repeat (4) @(posedge clk);
    do_reset();
    chk("mid_irq", {31'b0, irq}, 32'd0);
    rchk("mid_status", 8'h09, 32'h1);
    rchk("mid_blocks", 8'h0e, 32'h0);
    rchk("mid_ctr_lo", 8'h0c, 32'h0);
    rchk("mid_rounds", 8'h0b, 32'h14);
    rchk("mid_out0", 8'h80, 32'h0);
    repeat (30) @(posedge clk);
    rchk("mid_status_hold", 8'h09, 32'h1);
    rchk("mid_blocks_hold", 8'h0e, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
